fir_coeff_loader: RTL

Coefficient loader for `fir_datapath`. It accepts FIR taps one at a time on a narrow HWPE-Stream sink and assembles them into an `NB_TAPS`-wide register bank. Once all taps are loaded, it presents the bank on a wide HWPE-Stream source `h` with `valid` held high, acting as a persistent parameter stream. It sits between the streamer or TCDM-side coefficient source and the `h` port of `fir_datapath`.

---
 rtl/fir_coeff_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/fir_coeff_loader.sv
// Collects NB_TAPS coefficients from a narrow stream into a tap bank and
// presents the bank as a persistent wide parameter stream for fir_datapath.
module fir_coeff_loader #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned NB_TAPS    = 50,
  parameter int unsigned CNT_WIDTH  = $clog2(NB_TAPS + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic                                  load_i,
  input  logic                                  coeff_valid_i,
  output logic                                  coeff_ready_o,
  input  logic [DATA_WIDTH-1:0]                 coeff_data_i,
  input  logic [(DATA_WIDTH+7)/8-1:0]           coeff_strb_i,
  output logic                                  h_valid_o,
  input  logic                                  h_ready_i,
  output logic [DATA_WIDTH*NB_TAPS-1:0]         h_data_o,
  output logic [(DATA_WIDTH*NB_TAPS+7)/8-1:0]   h_strb_o,
  output logic                                  busy_o,
  output logic                                  loaded_o,
  output logic [CNT_WIDTH-1:0]                  count_o
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} stateE;

  stateE                         state_q;
  logic [CNT_WIDTH-1:0]          count_q;
  logic [DATA_WIDTH*NB_TAPS-1:0] bank_q;
  logic                          coeffReady_q;
  logic                          hValid_q;
  logic                          busy_q;
  logic                          loaded_q;

  // h is a parameter stream: its handshakes never consume the bank, and
  // coeff strobes are meaningless because every tap is written whole.
  logic unusedInputs;
  assign unusedInputs = ^{coeff_strb_i, h_ready_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      bank_q       <= '0;
      coeffReady_q <= 1'b0;
      hValid_q     <= 1'b0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (load_i) begin
            state_q      <= LOAD;
            count_q      <= '0;
            coeffReady_q <= 1'b1;
            hValid_q     <= 1'b0;
            busy_q       <= 1'b1;
            loaded_q     <= 1'b0;
          end
        end
        LOAD: begin
          if (coeff_valid_i) begin
            // Only the slot addressed by count is rewritten; older taps persist.
            for (int t = 0; t < int'(NB_TAPS); t++) begin
              if (count_q == CNT_WIDTH'(t)) begin
                bank_q[t*DATA_WIDTH +: DATA_WIDTH] <= coeff_data_i;
              end
            end
            count_q <= count_q + CNT_WIDTH'(1);
            if (count_q == CNT_WIDTH'(NB_TAPS - 1)) begin
              state_q      <= HOLD;
              coeffReady_q <= 1'b0;
              hValid_q     <= 1'b1;
              busy_q       <= 1'b0;
              loaded_q     <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          count_q      <= '0;
          coeffReady_q <= 1'b0;
          hValid_q     <= 1'b0;
          busy_q       <= 1'b0;
          loaded_q     <= 1'b0;
        end
      endcase
    end
  end

  assign coeff_ready_o = coeffReady_q;
  assign h_valid_o     = hValid_q;
  assign h_data_o      = bank_q;
  assign h_strb_o      = '1;
  assign busy_o        = busy_q;
  assign loaded_o      = loaded_q;
  assign count_o       = count_q;

endmodule
